// File: rtl/beamformer_pkg.sv
// beamformer_pkg: shared defaults, sample type and delay-width helper for the delay-and-sum beamformer
package beamformer_pkg;
  localparam int DEF_NUM_LINES   = 4;
  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_SLOT_BITS   = 32;
  localparam int DEF_DEPTH       = 8;
  typedef logic signed [DEF_SAMPLE_BITS-1:0] sample_t;
  function automatic int delay_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/mic_delay_line.sv
// mic_delay_line: per-microphone circular sample buffer with a combinational delayed tap
//   clk, rst_n : clock, async active-low reset (clears every entry)
//   we, wptr   : frame write strobe and shared write pointer
//   delay      : applied delay in frames; 0 returns the entry just written
//   din, tap   : sample to store, delayed sample out
module mic_delay_line
  import beamformer_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int DW          = delay_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [DW-1:0]          wptr,
  input  logic [DW-1:0]          delay,
  input  logic [SAMPLE_BITS-1:0] din,
  output logic [SAMPLE_BITS-1:0] tap
);
  logic [SAMPLE_BITS-1:0] mem [DEPTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we) mem[wptr] <= din;
  // wptr already points past the newest entry, hence the extra -1; DEPTH is a power of 2 so wrap is free
  assign tap = mem[wptr - DW'(1) - delay];
endmodule

// File: rtl/delay_sum_beamformer.sv
// delay_sum_beamformer: I2S multi-mic delay-and-sum beamformer producing a mono I2S stream
//   clk, rst_n        : system/bit clock, async active-low reset
//   sd_in             : NUM_LINES stereo I2S lines (line k left = mic 2k, right = mic 2k+1)
//   cfg_sel/data/we   : serial MSB-first load of the per-mic shadow delay
//   ws_o, sd_out      : generated word select and beamformed serial data (same word both slots)
//   frame_o           : one-clock pulse while the frame counter is 0
//   BEAMFORMER_SATURATE_EN defined: saturate the full sum; undefined: average (>>> log2 M)
module delay_sum_beamformer
  import beamformer_pkg::*;
#(
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LINES-1:0]            sd_in,
  input  logic [$clog2(2*NUM_LINES)-1:0]  cfg_sel,
  input  logic                            cfg_data,
  input  logic                            cfg_we,
  output logic                            ws_o,
  output logic                            sd_out,
  output logic                            frame_o
);
  localparam int M  = 2 * NUM_LINES;
  localparam int MW = $clog2(M);
  localparam int CW = $clog2(2 * SLOT_BITS);
  localparam int BW = $clog2(SLOT_BITS);
  localparam int DW = delay_width(DEPTH);
  localparam int SW = SAMPLE_BITS + MW;
  logic [CW-1:0]          cnt;
  logic [BW-1:0]          b;
  logic [DW-1:0]          wptr;
  logic                   wrap, in_word;
  logic [SAMPLE_BITS-1:0] tap [M];
  logic signed [SW-1:0]   sum;
  logic [SAMPLE_BITS-1:0] scaled, out_word;
  logic [BW-1:0]          idx;
  assign b       = cnt[BW-1:0];
  assign ws_o    = cnt[CW-1];
  assign wrap    = &cnt;
  // one-bit I2S delay: data bits live at slot positions 1..SAMPLE_BITS
  assign in_word = (b != '0) && (b <= BW'(SAMPLE_BITS));
  assign idx     = BW'(SAMPLE_BITS) - b;
  assign sd_out  = in_word && |(out_word & (SAMPLE_BITS'(1) << idx));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      wptr     <= '0;
      frame_o  <= 1'b0;
      out_word <= '0;
    end else begin
      cnt     <= cnt + CW'(1);
      frame_o <= wrap;
      if (wrap) wptr <= wptr + DW'(1);
      if (cnt == '0) out_word <= scaled;
    end
  for (genvar m = 0; m < M; m++) begin : g_mic
    logic [SAMPLE_BITS-1:0] sr;
    logic [DW-1:0]          shadow, active;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        sr     <= '0;
        shadow <= '0;
        active <= '0;
      end else begin
        if (in_word && ws_o == 1'(m % 2)) sr <= {sr[SAMPLE_BITS-2:0], sd_in[m/2]};
        if (cfg_we && cfg_sel == MW'(m)) shadow <= DW'({shadow, cfg_data});
        if (wrap) active <= shadow;
      end
    mic_delay_line #(.SAMPLE_BITS(SAMPLE_BITS), .DEPTH(DEPTH), .DW(DW)) u_line (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (wrap),
      .wptr (wptr),
      .delay(active),
      .din  (sr),
      .tap  (tap[m])
    );
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < M; i++) sum = sum + {{MW{tap[i][SAMPLE_BITS-1]}}, tap[i]};
  end
`ifdef BEAMFORMER_SATURATE_EN
  // in range when all bits above the sample sign bit agree with it
  assign scaled = (&sum[SW-1:SAMPLE_BITS-1] || ~|sum[SW-1:SAMPLE_BITS-1]) ? sum[SAMPLE_BITS-1:0]
                : {sum[SW-1], {(SAMPLE_BITS-1){~sum[SW-1]}}};
`else
  assign scaled = SAMPLE_BITS'(sum >>> MW);
`endif
endmodule

// File: tb/tb_delay_sum_beamformer.sv
// tb_delay_sum_beamformer: frame-level directed checks of the delay-and-sum beamformer
module tb_delay_sum_beamformer;
  typedef struct {
    logic [7:0][15:0] w;
    int               cm;
    int               cv;
    logic [15:0]      ea;
    logic [15:0]      es;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sd_in = '0;
  logic [2:0] cfg_sel = '0;
  logic       cfg_data = 1'b0, cfg_we = 1'b0;
  logic       ws_o, sd_out, frame_o;
  logic [5:0] tcnt;
  logic       wrapped;
  int         checks = 0, errors = 0;
  vec_t       tbl [19];
  delay_sum_beamformer dut (
    .clk(clk), .rst_n(rst_n), .sd_in(sd_in), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_we(cfg_we), .ws_o(ws_o), .sd_out(sd_out), .frame_o(frame_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt    <= '0;
      wrapped <= 1'b0;
    end else begin
      tcnt <= tcnt + 6'd1;
      if (tcnt == 6'd63) wrapped <= 1'b1;
    end
  function automatic logic [15:0] pick(input logic [15:0] avg, input logic [15:0] sat);
`ifdef BEAMFORMER_SATURATE_EN
    return sat;
`else
    return avg;
`endif
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic run_frame(input logic [7:0][15:0] w, input int cm, input int cv,
                           output logic [15:0] l, output logic [15:0] r, output int bad);
    int k, b, ws, bi;
    l = '0; r = '0; bad = 0; k = 0;
    while (tcnt != 6'd0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (tcnt != 6'd0) begin
      bad = 1000;
      return;
    end
    for (int c = 0; c < 64; c++) begin
      b  = c % 32;
      ws = c / 32;
      bi = (b >= 1 && b <= 16) ? 16 - b : 0;
      for (int i = 0; i < 4; i++) sd_in[i] = (b >= 1 && b <= 16) ? w[2*i+ws][bi] : 1'b0;
      cfg_we   = cm >= 0 && c >= 10 && c <= 12;
      cfg_sel  = 3'(cm < 0 ? 0 : cm);
      cfg_data = cfg_we && (((cv >> (cfg_we ? 12 - c : 0)) & 1) != 0);
      if (b >= 1 && b <= 16) begin
        if (ws == 0) l[bi] = sd_out;
        else r[bi] = sd_out;
      end else if (sd_out !== 1'b0) bad++;
      if (ws_o !== ws[0]) bad++;
      if (frame_o !== (c == 0 && wrapped)) bad++;
      if (tcnt != 6'(c)) bad++;
      @(negedge clk);
    end
    sd_in  = '0;
    cfg_we = 1'b0;
  endtask
  initial begin
    logic [15:0] l, r, e;
    logic [7:0][15:0] w;
    int bad, n, k;
    for (int i = 0; i < 19; i++) tbl[i] = '{w: '0, cm: -1, cv: 0, ea: 16'h0, es: 16'h0};
    tbl[0].w = {8{16'h7FFF}};
    tbl[1].w = {8{16'h8000}};                  tbl[1].ea = 16'h7FFF; tbl[1].es = 16'h7FFF;
    tbl[2].w[0] = 16'h1000; tbl[2].w[1] = 16'h2000; tbl[2].w[2] = 16'hF000;
                                               tbl[2].ea = 16'h8000; tbl[2].es = 16'h8000;
    tbl[3].w[4] = 16'h7000; tbl[3].w[5] = 16'h7000;
                                               tbl[3].ea = 16'h0400; tbl[3].es = 16'h2000;
    tbl[4].w[6] = 16'h8000; tbl[4].w[7] = 16'h8000;
                                               tbl[4].ea = 16'h1C00; tbl[4].es = 16'h7FFF;
    tbl[5].cm = 0; tbl[5].cv = 3;              tbl[5].ea = 16'hE000; tbl[5].es = 16'h8000;
    tbl[6].w[0] = 16'h0100;                    tbl[6].ea = 16'h0200; tbl[6].es = 16'h1000;
    tbl[10].w[2] = 16'h0400;                   tbl[10].ea = 16'h0020; tbl[10].es = 16'h0100;
    tbl[11].w[2] = 16'h0800; tbl[11].cm = 2; tbl[11].cv = 5;
                                               tbl[11].ea = 16'h0080; tbl[11].es = 16'h0400;
    tbl[16].ea = 16'h0080; tbl[16].es = 16'h0400;
    tbl[17].ea = 16'h0100; tbl[17].es = 16'h0800;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {29'd0, ws_o, sd_out, frame_o}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      run_frame(tbl[i].w, tbl[i].cm, tbl[i].cv, l, r, bad);
      e = pick(tbl[i].ea, tbl[i].es);
      chk($sformatf("vec%0d_left", i), {16'd0, l}, {16'd0, e});
      chk($sformatf("vec%0d_right", i), {16'd0, r}, {16'd0, e});
      chk($sformatf("vec%0d_framing", i), bad, 0);
    end
    k = 0;
    while (tcnt != 6'd20 && k < 200) begin
      @(negedge clk);
      k++;
    end
    sd_in = '1;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("midreset%0d_outputs", i), {29'd0, ws_o, sd_out, frame_o}, 32'd0);
    end
    sd_in = '0;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (ws_o) break;
    end
    chk("ws_first_rise", n, 32);
    @(negedge clk);
    for (int f = 0; f < 27; f++) begin
      w = '0;
      w[1] = 16'(16'h0100 * (f + 1));
      run_frame(w, f == 0 ? 1 : -1, 7, l, r, bad);
      e = (f >= 8) ? pick(16'(16'h0020 * (f - 7)), 16'(16'h0100 * (f - 7))) : 16'h0;
      chk($sformatf("wrap%0d_left", f), {16'd0, l}, {16'd0, e});
      chk($sformatf("wrap%0d_right", f), {16'd0, r}, {16'd0, e});
      chk($sformatf("wrap%0d_framing", f), bad, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/delay_sum_beamformer.md
# delay_sum_beamformer

Parametrised delay-and-sum beamformer core. It takes NUM_LINES stereo I2S data lines (2·NUM_LINES microphones) and stores each microphone's samples in its own circular delay buffer. It applies a separately programmable integer-sample delay to each microphone, sums the delayed samples, and sends the result out as a mono I2S stream on both slots. It generates its own word-select from the system clock and replaces the fixed two-microphone beamformer top-level datapath.

## Interface
- NUM_LINES, 4: number of I2S input data lines; microphone count M = 2·NUM_LINES (line k left = mic 2k, right = mic 2k+1)
- SAMPLE_BITS, 16: signed PCM sample width, MSB first
- SLOT_BITS, 32: clocks per ws half-frame; power of 2, ≥ SAMPLE_BITS+1
- DEPTH, 8: delay buffer depth in frames; power of 2, ≥ 2; delay width DW = $clog2(DEPTH)
- clk  in  1  system clock, also the I2S bit clock
- rst_n  in  1  asynchronous, active-low reset
- sd_in  in  NUM_LINES  I2S serial data, sampled on rising clk
- cfg_sel  in  $clog2(M)  selects which microphone's delay register is written
- cfg_data  in  1  serial delay bit, MSB first
- cfg_we  in  1  when high, shifts cfg_data into the selected delay register on rising clk
- ws_o  out  1  word select (0 = left slot, 1 = right slot)
- sd_out  out  1  serial beamformed output, I2S format
- frame_o  out  1  one-clock pulse at each frame boundary

## Operation
- Frame counter cnt, width $clog2(2·SLOT_BITS):
  - Increments on every clk; wraps at 2·SLOT_BITS−1 → 0.
  - ws_o = cnt MSB.
  - Slot bit index b = cnt mod SLOT_BITS.
- Capture:
  - For b in 1..SAMPLE_BITS (one-bit I2S delay), each line shifts sd_in into its left or right shift register, chosen by ws_o.
  - Bits at b = 0 and b > SAMPLE_BITS are ignored.
- Frame boundary (the edge where cnt wraps to 0):
  - All M captured samples are written into their buffers at the shared write pointer wptr, and wptr increments mod DEPTH.
  - Shadow delays are copied into active delays.
  - frame_o pulses high during cnt = 0.
- Tap read for mic m:
  - Reads entry (wptr − 1 − delay_m) mod DEPTH.
  - delay 0 gives the sample just written; delay DEPTH−1 gives the oldest entry.
- Sum:
  - Signed sum of the M taps, width SAMPLE_BITS + $clog2(M), no overflow possible.
  - Scaled to SAMPLE_BITS (see Configuration).
  - Registered into out_word at the edge where cnt becomes 1.
- Output:
  - sd_out = out_word[SAMPLE_BITS − b] for b in 1..SAMPLE_BITS, in both slots; 0 otherwise.
  - Combinational decode of the registered out_word and cnt only.
- Delay programming:
  - cfg_we high: shadow[cfg_sel] ← {shadow[cfg_sel][DW−2:0], cfg_data}.
  - cfg_sel ≥ M is ignored.
  - Shadow writes are allowed at any time; active delays change only at a frame boundary.

## Timing
- Reset (asynchronous, rst_n low) clears:
  - cnt, wptr, shift registers, buffer contents, shadow and active delays, out_word.
  - Outputs: ws_o = 0, sd_out = 0, frame_o = 0.
- First frame boundary occurs 2·SLOT_BITS clocks after reset release.
- Latency:
  - A sample captured in frame N, with delay d, first appears at sd_out in frame N+1+d, starting at cnt = 1.
  - The same word is output in the left and right slots.
- Simultaneous events:
  - cfg_we on the boundary edge shifts the shadow register; the active delay gets the pre-shift shadow value.
  - That newest bit takes effect one frame later.
- Wrap-around: wptr wraps silently; tap arithmetic is mod DEPTH with no ordering hazard.
- Reset mid-frame: partial samples are discarded and the frame restarts at cnt = 0.

## Configuration
- BEAMFORMER_SATURATE_EN:
  - Defined: output = full sum saturated to the signed range [−2^(SAMPLE_BITS−1), 2^(SAMPLE_BITS−1)−1].
  - Undefined: output = full sum arithmetically right-shifted by $clog2(M) (average, truncation toward −∞).

## Structure
- Package beamformer_pkg holds:
  - Default parameter constants.
  - Helper function for delay width.
  - Typedef for the signed sample type.
- Sub-module mic_delay_line, one instance per microphone:
  - DEPTH×SAMPLE_BITS circular buffer.
  - Write enable and write pointer shared from the top level.
  - Combinational tap output for the applied delay.
- Top level holds the frame counter, capture shift registers, config registers, adder tree and output serializer.

## Test plan
- Reset: hold rst_n low mid-frame, then release.
  - Outputs are 0 during reset.
  - ws_o first rises SLOT_BITS clocks after release.
  - frame_o pulses every 2·SLOT_BITS clocks.
- Impulse with delay:
  - Setup: delay_0 = 3, all other mics silent.
  - Stimulus: mic 0 receives 0x0100 for one frame.
  - Expected: sd_out carries 0x0100 (saturate build) or 0x0020 (M = 8, average build) in exactly the 4th frame after capture, and 0 in all other frames.
- Full-scale sum:
  - All 8 mics receive 0x7FFF with delay 0.
  - Saturate build: output 0x7FFF; average build: output 0x7FFF.
  - All mics at 0x8000: output 0x8000 in both builds.
- Mid-frame config change:
  - Shift delay 5 into mic 2 at cnt = 10.
  - Old delay stays active until the next boundary; the new delay applies from that boundary.
- Ignored select: cfg_sel = M with cfg_we high changes no delay register.
- Wrap-around:
  - Run 3·DEPTH frames with a ramp on mic 1 and delay DEPTH−1.
  - Output equals the ramp lagged by DEPTH frames, with no discontinuity at wptr wrap.
